// File: rtl/ls_ordered_return_buffer_if.sv
// Bus bundle for the load-return buffer: LSQ issue, raw sub-unit returns,
// CSR read result and the writeback handshake. The slave side is the buffer.
interface ls_ordered_return_buffer_if #(
    parameter int NUM_SUB_UNITS = 3,
    parameter int SUB_UNIT_W    = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1,
    parameter int ID_W          = 3
);
    // Issue side (LSQ)
    logic                          issue_valid;
    logic                          issue_ready;
    logic [SUB_UNIT_W-1:0]         issue_subunit;
    logic [2:0]                    issue_fn3;
    logic [1:0]                    issue_byte_addr;
    logic [ID_W-1:0]               issue_id;

    // Raw data returning from the sub-units, one strobe and word per unit
    logic [NUM_SUB_UNITS-1:0]      unit_data_valid;
    logic [32*NUM_SUB_UNITS-1:0]   unit_data;

    // CSR read result sharing the writeback port
    logic                          csr_done;
    logic [31:0]                   csr_rd;
    logic [ID_W-1:0]               csr_id;

    // Writeback
    logic                          wb_done;
    logic [31:0]                   wb_rd;
    logic [ID_W-1:0]               wb_id;
    logic                          wb_ack;

    // Environment view: LSQ, sub-units, CSR file and writeback stage
    modport master (
        output issue_valid, issue_subunit, issue_fn3, issue_byte_addr, issue_id,
        input  issue_ready,
        output unit_data_valid, unit_data,
        output csr_done, csr_rd, csr_id,
        input  wb_done, wb_rd, wb_id,
        output wb_ack
    );

    // Buffer view
    modport slave (
        input  issue_valid, issue_subunit, issue_fn3, issue_byte_addr, issue_id,
        output issue_ready,
        input  unit_data_valid, unit_data,
        input  csr_done, csr_rd, csr_id,
        output wb_done, wb_rd, wb_id,
        input  wb_ack
    );
endinterface

// File: rtl/ls_ordered_return_buffer.sv
// Load-return stage of the load/store unit. Loads may target different
// sub-units back-to-back; each sub-unit's returns land in a small FIFO and a
// program-order queue decides which word retires next. The retiring word is
// byte-aligned, sign/zero-extended and held in a single output register until
// writeback acknowledges it. The head load's data can bypass its FIFO so a
// return in cycle t is visible on writeback in cycle t+1.
module ls_ordered_return_buffer #(
    parameter int NUM_SUB_UNITS = 3,
    parameter int SUB_UNIT_W    = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1,
    parameter int MAX_INFLIGHT  = 4,
    parameter int RETURN_DEPTH  = 2,
    parameter int ID_W          = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    ls_ordered_return_buffer_if.slave bus,
    output logic                     idle,
    output logic                     spurious_err
);

    localparam int QW = $clog2(MAX_INFLIGHT);
    localparam int CW = $clog2(RETURN_DEPTH + 1);
    localparam int FW = (RETURN_DEPTH > 1) ? $clog2(RETURN_DEPTH) : 1;

    localparam logic [QW:0]   Q_DEPTH   = (QW+1)'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(RETURN_DEPTH);
    localparam logic [FW-1:0] FIFO_LAST = FW'(RETURN_DEPTH - 1);

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;

    typedef struct packed {
        logic [2:0]            fn3;
        logic [1:0]            byte_addr;
        logic [ID_W-1:0]       id;
        logic [SUB_UNIT_W-1:0] subunit;
    } ord_entry_t;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} out_state_t;

    // Align the addressed halfword/byte to the bottom, then extend per fn3.
    // Unknown fn3 codes retire the aligned word untouched.
    function automatic logic [31:0] align_extend(input logic [31:0] w,
                                                 input logic [1:0]  ba,
                                                 input logic [2:0]  fn3);
        logic [31:0] a;
        a       = w;
        a[15:0] = ba[1] ? w[31:16] : w[15:0];
        a[7:0]  = ba[0] ? a[15:8]  : a[7:0];
        case (fn3)
            FN3_LB:  return {{24{a[7]}}, a[7:0]};
            FN3_LH:  return {{16{a[15]}}, a[15:0]};
            FN3_LW:  return a;
            FN3_LBU: return {24'd0, a[7:0]};
            FN3_LHU: return {16'd0, a[15:0]};
            default: return a;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Program-order queue (one extra pointer bit distinguishes full/empty)
    // ------------------------------------------------------------------
    ord_entry_t q_mem [MAX_INFLIGHT];
    logic [QW:0] q_rd, q_wr, q_count;
    logic        q_empty, q_full;
    ord_entry_t  head, new_entry;

    assign q_count = q_wr - q_rd;
    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == Q_DEPTH);
    assign head    = q_mem[q_rd[QW-1:0]];

    assign new_entry.fn3       = bus.issue_fn3;
    assign new_entry.byte_addr = bus.issue_byte_addr;
    assign new_entry.id        = bus.issue_id;
    assign new_entry.subunit   = bus.issue_subunit;

    // ------------------------------------------------------------------
    // Per-unit views exported by the FIFO generate blocks
    // ------------------------------------------------------------------
    logic [NUM_SUB_UNITS-1:0][31:0]   fifo_head;
    logic [NUM_SUB_UNITS-1:0][CW-1:0] occ;      // words buffered in FIFO u
    logic [NUM_SUB_UNITS-1:0][CW-1:0] cnt;      // loads owed to the output by unit u
    logic [NUM_SUB_UNITS-1:0]         is_head, inc, pop, bypass, push, spur;

    logic        head_avail;
    logic [31:0] head_word;
    logic        sel_cnt_ok;
    logic        issue_ready_c, issue_fire;
    logic        load, csr_take, csr_lost;
    logic        any_buf;

    out_state_t  state;
    logic [31:0] wb_rd_q;
    logic [ID_W-1:0] wb_id_q;
    logic        spur_q;

    // Pick the head load's data: a buffered word first, else the same-cycle return
    always_comb begin
        is_head    = '0;
        head_avail = 1'b0;
        head_word  = '0;
        for (int u = 0; u < NUM_SUB_UNITS; u++) begin
            is_head[u] = !q_empty && (head.subunit == SUB_UNIT_W'(u));
            if (is_head[u]) begin
                if (occ[u] != '0) begin
                    head_avail = 1'b1;
                    head_word  = fifo_head[u];
                end else if (bus.unit_data_valid[u]) begin
                    head_avail = 1'b1;
                    head_word  = bus.unit_data[32*u +: 32];
                end
            end
        end
    end

    // Per-unit credit check for the requested sub-unit; out-of-range indices never issue
    always_comb begin
        sel_cnt_ok = 1'b0;
        for (int u = 0; u < NUM_SUB_UNITS; u++) begin
            if (bus.issue_subunit == SUB_UNIT_W'(u))
                sel_cnt_ok = (cnt[u] < CNT_MAX);
        end
    end

    // Readiness uses registered counts only, so a retire never frees a slot
    // for an issue in the same cycle.
    assign issue_ready_c   = !q_full && sel_cnt_ok;
    assign bus.issue_ready = issue_ready_c;
    assign issue_fire      = bus.issue_valid && issue_ready_c;

    // The output register takes a new load when it is free or being drained
    assign load     = head_avail && ((state == S_EMPTY) || bus.wb_ack);
    assign csr_take = bus.csr_done && !load && ((state == S_EMPTY) || bus.wb_ack);
    assign csr_lost = bus.csr_done && !csr_take;

    // Per-unit push/pop decisions. A return is spurious when every load owed by
    // the unit already has its word buffered; a same-cycle retire does not help.
    always_comb begin
        inc    = '0;
        pop    = '0;
        bypass = '0;
        spur   = '0;
        push   = '0;
        for (int u = 0; u < NUM_SUB_UNITS; u++) begin
            inc[u]    = issue_fire && (bus.issue_subunit == SUB_UNIT_W'(u));
            pop[u]    = load && is_head[u];
            bypass[u] = pop[u] && (occ[u] == '0);
            spur[u]   = bus.unit_data_valid[u] && (cnt[u] == occ[u]);
            push[u]   = bus.unit_data_valid[u] && !spur[u] && !bypass[u];
        end
    end

    // ------------------------------------------------------------------
    // Per-unit return FIFOs and outstanding-load counters
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SUB_UNITS; g++) begin : g_unit
        logic [31:0]   mem [RETURN_DEPTH];
        logic [FW-1:0] rd_ptr, wr_ptr;
        logic [CW-1:0] fill, credit;
        logic          fifo_pop;

        assign fifo_pop     = pop[g] && !bypass[g];
        assign fifo_head[g] = mem[rd_ptr];
        assign occ[g]       = fill;
        assign cnt[g]       = credit;

        // Word storage; contents are qualified by fill so no reset is needed
        always_ff @(posedge clk) begin
            if (push[g])
                mem[wr_ptr] <= bus.unit_data[32*g +: 32];
        end

        // Circular pointers and occupancy
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push[g])
                    wr_ptr <= (wr_ptr == FIFO_LAST) ? '0 : wr_ptr + 1'b1;
                if (fifo_pop)
                    rd_ptr <= (rd_ptr == FIFO_LAST) ? '0 : rd_ptr + 1'b1;
                fill <= fill + CW'(push[g]) - CW'(fifo_pop);
            end
        end

        // Loads issued to this unit that have not yet reached the output register
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                credit <= '0;
            else
                credit <= credit + CW'(inc[g]) - CW'(pop[g]);
        end
    end

    // Order-queue entry storage, qualified by the pointers
    always_ff @(posedge clk) begin
        if (issue_fire)
            q_mem[q_wr[QW-1:0]] <= new_entry;
    end

    // Order-queue pointers: push on issue, pop when the head retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_rd <= '0;
            q_wr <= '0;
        end else begin
            if (issue_fire)
                q_wr <= q_wr + 1'b1;
            if (load)
                q_rd <= q_rd + 1'b1;
        end
    end

    // Output register FSM plus the sticky protocol-error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_EMPTY;
            wb_rd_q <= '0;
            wb_id_q <= '0;
            spur_q  <= 1'b0;
        end else begin
            if (load) begin
                state   <= S_FULL;
                wb_rd_q <= align_extend(head_word, head.byte_addr, head.fn3);
                wb_id_q <= head.id;
            end else if (csr_take) begin
                state   <= S_FULL;
                wb_rd_q <= bus.csr_rd;
                wb_id_q <= bus.csr_id;
            end else if (bus.wb_ack) begin
                state   <= S_EMPTY;
            end
            if ((|spur) || csr_lost)
                spur_q <= 1'b1;
        end
    end

    assign bus.wb_done  = (state == S_FULL);
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_id    = wb_id_q;
    assign spurious_err = spur_q;

    // Any word still parked in a return FIFO keeps the block busy
    always_comb begin
        any_buf = 1'b0;
        for (int u = 0; u < NUM_SUB_UNITS; u++) begin
            if (occ[u] != '0)
                any_buf = 1'b1;
        end
    end

    assign idle = q_empty && !any_buf && (state == S_EMPTY);

endmodule

// File: tb/tb_ls_ordered_return_buffer.sv
// Bench for ls_ordered_return_buffer: directed cases followed by random
// traffic, checked every cycle against a queue-level model of the loads.
module tb_ls_ordered_return_buffer;
    localparam int N     = 3;
    localparam int SW    = 2;
    localparam int MAXI  = 4;
    localparam int DEPTH = 2;
    localparam int IDW   = 3;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic idle, spurious_err;

    ls_ordered_return_buffer_if #(.NUM_SUB_UNITS(N), .SUB_UNIT_W(SW), .ID_W(IDW)) bus ();

    ls_ordered_return_buffer #(
        .NUM_SUB_UNITS(N), .SUB_UNIT_W(SW), .MAX_INFLIGHT(MAXI),
        .RETURN_DEPTH(DEPTH), .ID_W(IDW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .idle(idle), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     fn3;
        logic [1:0]     ba;
        logic [IDW-1:0] id;
        int             unit;
        bit             has;
        logic [31:0]    data;
    } ld_t;

    ld_t             ordq[$];      // loads not yet in the output register, program order
    bit              m_out_v;
    logic [31:0]     m_out_rd;
    logic [IDW-1:0]  m_out_id;
    bit              m_spur;
    int              npass = 0;
    int              ntot  = 0;
    logic [2:0]      fn3_tab [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    logic [IDW-1:0]  next_id = '0;

    // Expected writeback word: byte = byte 'ba' of the word, halfword = the
    // selected half with its low byte replaced by that byte.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] ba, logic [2:0] fn3);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] hw;
        sh = w >> (8 * ba);
        b  = sh[7:0];
        hw = ba[1] ? w[31:16] : w[15:0];
        hw[7:0] = b;
        case (fn3)
            LB:      return {{24{b[7]}}, b};
            LH:      return {{16{hw[15]}}, hw};
            LBU:     return {24'd0, b};
            LHU:     return {16'd0, hw};
            default: return {w[31:16], hw};
        endcase
    endfunction

    function automatic int n_unit(int u);
        int n = 0;
        foreach (ordq[i]) if (ordq[i].unit == u) n++;
        return n;
    endfunction

    function automatic int n_pending(int u);
        int n = 0;
        foreach (ordq[i]) if (ordq[i].unit == u && !ordq[i].has) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_in();
        bus.issue_valid     = 1'b0;
        bus.issue_subunit   = '0;
        bus.issue_fn3       = '0;
        bus.issue_byte_addr = '0;
        bus.issue_id        = '0;
        bus.unit_data_valid = '0;
        bus.unit_data       = '0;
        bus.csr_done        = 1'b0;
        bus.csr_rd          = '0;
        bus.csr_id          = '0;
        bus.wb_ack          = 1'b0;
    endtask

    task automatic drive_issue(int u, logic [2:0] fn3, logic [1:0] ba, logic [IDW-1:0] id);
        bus.issue_valid     = 1'b1;
        bus.issue_subunit   = SW'(u);
        bus.issue_fn3       = fn3;
        bus.issue_byte_addr = ba;
        bus.issue_id        = id;
    endtask

    task automatic drive_ret(int u, logic [31:0] d);
        bus.unit_data_valid[u]     = 1'b1;
        bus.unit_data[32*u +: 32] = d;
    endtask

    // Advance the model by one cycle using the inputs currently driven
    task automatic model_step(bit fire);
        bit found;
        for (int u = 0; u < N; u++) begin
            if (bus.unit_data_valid[u]) begin
                found = 0;
                foreach (ordq[i]) begin
                    if (!found && ordq[i].unit == u && !ordq[i].has) begin
                        ordq[i].has  = 1;
                        ordq[i].data = bus.unit_data[32*u +: 32];
                        found = 1;
                    end
                end
                if (!found) m_spur = 1;
            end
        end
        if (ordq.size() > 0 && ordq[0].has && (!m_out_v || bus.wb_ack)) begin
            m_out_v  = 1;
            m_out_rd = ref_load(ordq[0].data, ordq[0].ba, ordq[0].fn3);
            m_out_id = ordq[0].id;
            void'(ordq.pop_front());
        end else if (bus.csr_done) begin
            if (!m_out_v || bus.wb_ack) begin
                m_out_v  = 1;
                m_out_rd = bus.csr_rd;
                m_out_id = bus.csr_id;
            end else begin
                m_spur = 1;
            end
        end else if (bus.wb_ack) begin
            m_out_v = 0;
        end
        if (fire)
            ordq.push_back('{fn3: bus.issue_fn3, ba: bus.issue_byte_addr, id: bus.issue_id,
                             unit: int'(bus.issue_subunit), has: 1'b0, data: 32'd0});
    endtask

    // One clock with full output comparison against the model
    task automatic tick();
        bit rdy;
        #1;
        rdy = (ordq.size() < MAXI) && (n_unit(int'(bus.issue_subunit)) < DEPTH);
        chk("issue_ready", 32'(bus.issue_ready), 32'(rdy));
        model_step(bus.issue_valid && rdy);
        @(posedge clk);
        #1;
        chk("wb_done", 32'(bus.wb_done), 32'(m_out_v));
        if (m_out_v) begin
            chk("wb_rd", bus.wb_rd, m_out_rd);
            chk("wb_id", 32'(bus.wb_id), 32'(m_out_id));
        end
        chk("idle", 32'(idle), 32'(ordq.size() == 0 && !m_out_v));
        chk("spurious_err", 32'(spurious_err), 32'(m_spur));
    endtask

    task automatic single_load(int u, logic [2:0] fn3, logic [1:0] ba, logic [IDW-1:0] id,
                               logic [31:0] d, logic [31:0] exp, string tag);
        clear_in(); drive_issue(u, fn3, ba, id); tick();
        clear_in(); drive_ret(u, d); tick();
        chk({tag, "_done"}, 32'(bus.wb_done), 32'd1);
        chk(tag, bus.wb_rd, exp);
        chk({tag, "_id"}, 32'(bus.wb_id), 32'(id));
        clear_in(); bus.wb_ack = 1'b1; tick();
        clear_in();
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (ordq.size() == 0 && !m_out_v) break;
            clear_in();
            for (int u = 0; u < N; u++)
                if (n_pending(u) > 0) drive_ret(u, $urandom);
            bus.wb_ack = 1'b1;
            tick();
        end
        clear_in();
        #1;
        chk("drain_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        clear_in();
        m_out_v = 0; m_out_rd = '0; m_out_id = '0; m_spur = 0;

        // Reset state
        #12;
        chk("rst_wb_done", 32'(bus.wb_done), 32'd0);
        chk("rst_wb_rd", bus.wb_rd, 32'd0);
        chk("rst_wb_id", 32'(bus.wb_id), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_spur", 32'(spurious_err), 32'd0);
        chk("rst_ready", 32'(bus.issue_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Alignment / extension, one load at a time (bypass latency)
        single_load(0, LW,  2'd0, 3'd1, 32'hDEADBEEF, 32'hDEADBEEF, "lw_word");
        single_load(1, LB,  2'd3, 3'd2, 32'h80FF0000, 32'hFFFFFF80, "lb_sext");
        single_load(2, LBU, 2'd3, 3'd3, 32'h80FF0000, 32'h00000080, "lbu_zext");
        single_load(0, LHU, 2'd2, 3'd4, 32'h80FF0000, 32'h000080FF, "lhu_zext");
        single_load(1, LH,  2'd2, 3'd5, 32'h80FF0000, 32'hFFFF80FF, "lh_sext");
        single_load(2, LH,  2'd1, 3'd6, 32'h00008A00, 32'hFFFF8A8A, "lh_odd");

        // Program order across units: unit0 returns first but id2 retires first
        clear_in(); drive_issue(1, LW, 2'd0, 3'd2); tick();
        clear_in(); drive_issue(0, LW, 2'd0, 3'd3); tick();
        clear_in(); drive_ret(0, 32'h00000333); tick();
        chk("ooo_wait", 32'(bus.wb_done), 32'd0);
        clear_in(); drive_ret(1, 32'h00000222); tick();
        chk("ooo_first_id", 32'(bus.wb_id), 32'd2);
        clear_in(); bus.wb_ack = 1'b1; tick();
        chk("ooo_second_done", 32'(bus.wb_done), 32'd1);
        chk("ooo_second_id", 32'(bus.wb_id), 32'd3);
        chk("ooo_second_rd", bus.wb_rd, 32'h00000333);
        clear_in(); bus.wb_ack = 1'b1; tick();

        // Per-unit credit exhaustion
        clear_in(); drive_issue(0, LW, 2'd0, 3'd6); tick();
        clear_in(); drive_issue(0, LW, 2'd0, 3'd7); tick();
        clear_in(); bus.issue_subunit = 2'd0; #1;
        chk("credit_u0_blocked", 32'(bus.issue_ready), 32'd0);
        bus.issue_subunit = 2'd1; #1;
        chk("credit_u1_open", 32'(bus.issue_ready), 32'd1);
        drain();

        // Queue full while writeback stalls, then drain back-to-back
        clear_in(); drive_issue(0, LW, 2'd0, 3'd0); tick();
        clear_in(); drive_issue(1, LW, 2'd0, 3'd1); tick();
        clear_in(); drive_issue(2, LW, 2'd0, 3'd2); tick();
        clear_in(); drive_issue(1, LW, 2'd0, 3'd3); tick();
        clear_in(); drive_ret(0, 32'hA0A0A0A0); drive_ret(1, 32'hB1B1B1B1);
        drive_ret(2, 32'hC2C2C2C2); tick();
        clear_in(); drive_ret(1, 32'hD3D3D3D3); drive_issue(2, LW, 2'd0, 3'd4); tick();
        clear_in(); drive_issue(0, LW, 2'd0, 3'd5); #1;
        chk("qfull_ready", 32'(bus.issue_ready), 32'd0);
        tick();
        clear_in(); drive_ret(2, 32'hE4E4E4E4); tick();
        clear_in(); tick(); tick();
        chk("stall_id", 32'(bus.wb_id), 32'd0);
        chk("stall_rd", bus.wb_rd, 32'hA0A0A0A0);
        for (int k = 1; k <= 4; k++) begin
            clear_in(); bus.wb_ack = 1'b1; tick();
            chk("release_done", 32'(bus.wb_done), 32'd1);
            chk("release_id", 32'(bus.wb_id), 32'(k));
        end
        clear_in(); bus.wb_ack = 1'b1; tick();
        chk("release_empty", 32'(bus.wb_done), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            clear_in();
            if ($urandom_range(0, 99) < 60) begin
                drive_issue($urandom_range(0, N - 1), fn3_tab[$urandom_range(0, 6)],
                            2'($urandom_range(0, 3)), next_id);
                next_id++;
            end
            for (int u = 0; u < N; u++)
                if (n_pending(u) > 0 && $urandom_range(0, 99) < 50) drive_ret(u, $urandom);
            bus.wb_ack = ($urandom_range(0, 99) < 65);
            tick();
        end
        drain();

        // CSR result through the output register
        clear_in(); bus.csr_done = 1'b1; bus.csr_rd = 32'h12345678; bus.csr_id = 3'd5; tick();
        chk("csr_rd", bus.wb_rd, 32'h12345678);
        chk("csr_id", 32'(bus.wb_id), 32'd5);
        clear_in(); bus.wb_ack = 1'b1; tick();

        // Return with nothing outstanding
        clear_in(); drive_ret(2, 32'h55555555); tick();
        chk("spurious_unit2", 32'(spurious_err), 32'd1);

        // Reset in the middle of traffic
        clear_in(); drive_issue(0, LW, 2'd0, 3'd1); tick();
        clear_in(); drive_issue(1, LW, 2'd0, 3'd2); drive_ret(0, 32'h77777777); tick();
        clear_in();
        #2; rst = 1'b0; #1;
        chk("mid_rst_wb_done", 32'(bus.wb_done), 32'd0);
        chk("mid_rst_wb_rd", bus.wb_rd, 32'd0);
        chk("mid_rst_wb_id", 32'(bus.wb_id), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_spur", 32'(spurious_err), 32'd0);
        ordq.delete(); m_out_v = 0; m_spur = 0;
        @(posedge clk); #1;
        rst = 1'b1;

        // CSR pulse while the output is held: lost and flagged
        clear_in(); bus.csr_done = 1'b1; bus.csr_rd = 32'hCAFEF00D; bus.csr_id = 3'd1; tick();
        clear_in(); bus.csr_done = 1'b1; bus.csr_rd = 32'h0BADF00D; bus.csr_id = 3'd2; tick();
        chk("csr_lost_spur", 32'(spurious_err), 32'd1);
        chk("csr_lost_keep", bus.wb_rd, 32'hCAFEF00D);
        clear_in(); bus.wb_ack = 1'b1; tick();
        clear_in(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
